// File: rtl/pipe_pkg.sv
// Shared types and constants for the MIPS pipeline stall/flush sequencer.
// Holds the sequencer state encoding, stage-enable bundle and a few ISA opcodes.
package pipe_pkg;

    typedef enum logic [2:0] {
        ST_RUN      = 3'd0,
        ST_MEM_WAIT = 3'd1,
        ST_MDU_WAIT = 3'd2,
        ST_DRAIN    = 3'd3,
        ST_HALTED   = 3'd4
    } seqState_t;

    // Bit order of the packed struct matches {F, D, E, M, W}.
    typedef struct packed {
        logic f;
        logic d;
        logic e;
        logic m;
        logic w;
    } stageEn_t;

    localparam stageEn_t EN_ALL     = '{f: 1'b1, d: 1'b1, e: 1'b1, m: 1'b1, w: 1'b1};
    localparam stageEn_t EN_NONE    = '{f: 1'b0, d: 1'b0, e: 1'b0, m: 1'b0, w: 1'b0};
    localparam stageEn_t EN_MEMHOLD = '{f: 1'b0, d: 1'b0, e: 1'b0, m: 1'b0, w: 1'b1};
    localparam stageEn_t EN_MDUHOLD = '{f: 1'b0, d: 1'b0, e: 1'b0, m: 1'b1, w: 1'b1};

    localparam int DRAIN_CYCLES_DEF = 4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;
    localparam logic [5:0] FN_MULT  = 6'h18;
    localparam logic [5:0] FN_DIV   = 6'h1a;

endpackage

// File: rtl/stall_perf_counter.sv
// Saturating up-counter used to count pipeline stall cycles.
module stall_perf_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_stall_sequencer.sv
// Merges hazard-unit requests with memory wait, MDU busy and halt into per-stage
// enable/flush strobes; owns the halt drain sequence and the stall-cycle counter.
module pipe_stall_sequencer
    import pipe_pkg::*;
#(
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int CNT_W        = 32,
    parameter int MDU_MAX      = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_D,
    input  logic             redirect_D,
    input  logic             mdu_start_E,
    input  logic             mdu_done,
    input  logic             dmem_wait,
    input  logic             halt_req,
    output logic             en_F,
    output logic             en_D,
    output logic             en_E,
    output logic             en_M,
    output logic             en_W,
    output logic             flush_D,
    output logic             flush_E,
    output logic             halted,
    output logic             mdu_timeout,
    output logic [CNT_W-1:0] stall_count,
    output logic [2:0]       dbgState
);

    localparam int DW = $clog2(DRAIN_CYCLES + 1);
    localparam int MW = $clog2(MDU_MAX + 1);

    seqState_t state, stateNext;
    logic [DW-1:0] drainCnt, drainNext;
    logic [MW-1:0] mduCnt, mduCntNext;
    logic mduActive, mduActiveNext;
    logic donePending, pendingNext;
    logic timeoutQ, timeoutSet;
    logic doRun;
    stageEn_t en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_RUN;
            drainCnt    <= '0;
            mduCnt      <= '0;
            mduActive   <= 1'b0;
            donePending <= 1'b0;
            timeoutQ    <= 1'b0;
        end else begin
            state       <= stateNext;
            drainCnt    <= drainNext;
            mduCnt      <= mduCntNext;
            mduActive   <= mduActiveNext;
            donePending <= pendingNext;
            timeoutQ    <= timeoutQ | timeoutSet;
        end
    end

    always_comb begin
        en            = EN_ALL;
        flush_D       = 1'b0;
        flush_E       = 1'b0;
        halted        = 1'b0;
        stateNext     = state;
        drainNext     = drainCnt;
        mduCntNext    = mduCnt;
        mduActiveNext = mduActive;
        pendingNext   = donePending;
        timeoutSet    = 1'b0;
        doRun         = 1'b0;

        // Busy time keeps accruing while a memory wait interrupts the MDU.
        if (mduActive && (mduCnt != MW'(MDU_MAX))) begin
            mduCntNext = mduCnt + 1'b1;
        end

        case (state)
            ST_RUN: doRun = 1'b1;
            ST_MEM_WAIT: begin
                if (dmem_wait) begin
                    en = EN_MEMHOLD;
                    if (mduActive && mdu_done) pendingNext = 1'b1;
                end else if (mduActive && !donePending) begin
                    en      = EN_MDUHOLD;
                    flush_E = 1'b1;
                    if (mdu_done) begin
                        stateNext     = ST_RUN;
                        mduActiveNext = 1'b0;
                    end else begin
                        stateNext = ST_MDU_WAIT;
                    end
                end else begin
                    doRun         = 1'b1;
                    mduActiveNext = 1'b0;
                    pendingNext   = 1'b0;
                end
            end
            ST_MDU_WAIT: begin
                en      = EN_MDUHOLD;
                flush_E = (mduCnt != '0);
                if (dmem_wait) begin
                    en          = EN_MEMHOLD;
                    flush_E     = 1'b0;
                    stateNext   = ST_MEM_WAIT;
                    pendingNext = mdu_done;
                end else if (mdu_done) begin
                    stateNext     = ST_RUN;
                    mduActiveNext = 1'b0;
                end else if (mduCnt >= MW'(MDU_MAX)) begin
                    timeoutSet    = 1'b1;
                    stateNext     = ST_RUN;
                    mduActiveNext = 1'b0;
                end
            end
            ST_DRAIN: begin
                if (dmem_wait) begin
                    en = EN_MEMHOLD;
                end else begin
                    en.f    = 1'b0;
                    flush_D = 1'b1;
                    if (drainCnt == '0) stateNext = ST_HALTED;
                    else drainNext = drainCnt - 1'b1;
                end
            end
            ST_HALTED: begin
                en     = EN_NONE;
                halted = 1'b1;
            end
            default: stateNext = ST_RUN;
        endcase

        // RUN priority chain, also reused on the cycle a memory wait releases.
        if (doRun) begin
            stateNext = ST_RUN;
            if (dmem_wait) begin
                en        = EN_MEMHOLD;
                stateNext = ST_MEM_WAIT;
            end else if (mdu_start_E) begin
                en            = EN_MDUHOLD;
                stateNext     = ST_MDU_WAIT;
                mduActiveNext = 1'b1;
                mduCntNext    = '0;
                pendingNext   = 1'b0;
            end else if (load_use_D) begin
                en.f    = 1'b0;
                en.d    = 1'b0;
                flush_E = 1'b1;
            end else if (redirect_D) begin
                flush_D = 1'b1;
            end else if (halt_req) begin
                en.f      = 1'b0;
                flush_D   = 1'b1;
                drainNext = DW'(DRAIN_CYCLES - 1);
                stateNext = ST_DRAIN;
            end
        end
    end

    assign en_F        = en.f;
    assign en_D        = en.d;
    assign en_E        = en.e;
    assign en_M        = en.m;
    assign en_W        = en.w;
    assign mdu_timeout = timeoutQ;
    assign dbgState    = state;

    stall_perf_counter #(.W(CNT_W)) uStallCnt (
        .clk   (clk),
        .rst_n (rst_n),
        .inc   (!en.f && (state != ST_HALTED)),
        .count (stall_count)
    );

endmodule

// File: tb/tb_pipe_stall_sequencer.sv
// Directed bench: each step pushes its hand-computed expected output vector;
// a negedge monitor pops and compares against the DUT outputs.
module tb_pipe_stall_sequencer;

    // {en_F,en_D,en_E,en_M,en_W,flush_D,flush_E,halted,mdu_timeout}
    localparam logic [8:0] RUNO  = 9'b11111_00_0_0;
    localparam logic [8:0] LU    = 9'b00111_01_0_0;
    localparam logic [8:0] RD    = 9'b11111_10_0_0;
    localparam logic [8:0] MEMH  = 9'b00001_00_0_0;
    localparam logic [8:0] MDU0  = 9'b00011_00_0_0;
    localparam logic [8:0] MDUN  = 9'b00011_01_0_0;
    localparam logic [8:0] HLT   = 9'b01111_10_0_0;
    localparam logic [8:0] HALTD = 9'b00000_00_1_0;
    localparam logic [8:0] RUNTO = 9'b11111_00_0_1;
    localparam int W = 41;

    logic clk, rst_n;
    logic load_use_D, redirect_D, mdu_start_E, mdu_done, dmem_wait, halt_req;
    logic en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, halted, mdu_timeout;
    logic [31:0] stall_count;
    logic [2:0] dbgState;

    logic [W-1:0] exp_q[$];
    string name_q[$];
    int checks = 0;
    int passes = 0;

    pipe_stall_sequencer dut (
        .clk(clk), .rst_n(rst_n), .load_use_D(load_use_D), .redirect_D(redirect_D),
        .mdu_start_E(mdu_start_E), .mdu_done(mdu_done), .dmem_wait(dmem_wait),
        .halt_req(halt_req), .en_F(en_F), .en_D(en_D), .en_E(en_E), .en_M(en_M),
        .en_W(en_W), .flush_D(flush_D), .flush_E(flush_E), .halted(halted),
        .mdu_timeout(mdu_timeout), .stall_count(stall_count), .dbgState(dbgState)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver
    task automatic step(input logic rn, input logic lu, input logic rd, input logic ms,
                        input logic md, input logic dw, input logic hr,
                        input logic [8:0] eo, input int cnt, input string nm);
        @(posedge clk);
        #1;
        rst_n = rn; load_use_D = lu; redirect_D = rd; mdu_start_E = ms;
        mdu_done = md; dmem_wait = dw; halt_req = hr;
        exp_q.push_back({eo, 32'(cnt)});
        name_q.push_back(nm);
    endtask

    // monitor / scoreboard
    always @(negedge clk) begin
        logic [W-1:0] act, expv;
        string nm;
        if (exp_q.size() > 0) begin
            expv = exp_q.pop_front();
            nm = name_q.pop_front();
            act = {en_F, en_D, en_E, en_M, en_W, flush_D, flush_E, halted, mdu_timeout, stall_count};
            checks++;
            if (act === expv) passes++;
            else $display("FAIL %s: got flags=%b count=%0d, expected flags=%b count=%0d",
                          nm, act[40:32], act[31:0], expv[40:32], expv[31:0]);
        end
    end

    initial begin
        rst_n = 1'b1;
        {load_use_D, redirect_D, mdu_start_E, mdu_done, dmem_wait, halt_req} = '0;
        #1 rst_n = 1'b0;

        step(0, 0,0,0,0,0,0, RUNO, 0, "reset");
        step(1, 0,0,0,0,0,0, RUNO, 0, "idle");
        // single load-use bubble
        step(1, 1,0,0,0,0,0, LU,   0, "load_use");
        step(1, 0,0,0,0,0,0, RUNO, 1, "after_load_use");
        // load-use masks a same-cycle redirect
        step(1, 1,1,0,0,0,0, LU,   1, "lu_and_redirect");
        step(1, 0,1,0,0,0,0, RD,   2, "redirect");
        step(1, 0,0,0,0,0,0, RUNO, 2, "after_redirect");
        // mult/div with done 5 cycles after issue
        step(1, 0,0,1,0,0,0, MDU0, 2, "mdu_start");
        step(1, 0,0,0,0,0,0, MDU0, 3, "mdu_first");
        step(1, 0,0,0,0,0,0, MDUN, 4, "mdu_wait");
        step(1, 0,0,0,0,0,0, MDUN, 5, "mdu_wait");
        step(1, 0,0,0,0,0,0, MDUN, 6, "mdu_wait");
        step(1, 0,0,0,1,0,0, MDUN, 7, "mdu_done");
        step(1, 0,0,0,0,0,0, RUNO, 8, "after_mdu");
        // memory wait interrupts MDU; done lands inside the wait
        step(1, 0,0,1,0,0,0, MDU0, 8,  "mdu2_start");
        step(1, 0,0,0,0,0,0, MDU0, 9,  "mdu2_first");
        step(1, 0,0,0,0,1,0, MEMH, 10, "mdu2_dmem");
        step(1, 0,0,0,1,1,0, MEMH, 11, "mdu2_dmem_done");
        step(1, 0,0,0,0,1,0, MEMH, 12, "mdu2_dmem");
        step(1, 0,0,0,0,0,0, RUNO, 13, "mdu2_exit");
        step(1, 0,0,0,0,0,0, RUNO, 13, "mdu2_idle");
        // halt drain
        step(1, 0,0,0,0,0,1, HLT,   13, "halt_req");
        step(1, 0,0,0,0,0,1, HLT,   14, "drain");
        step(1, 0,0,0,0,0,1, HLT,   15, "drain");
        step(1, 0,0,0,0,0,1, HLT,   16, "drain");
        step(1, 0,0,0,0,0,1, HLT,   17, "drain_last");
        step(1, 0,0,0,0,0,1, HALTD, 18, "halted");
        step(1, 1,0,0,0,0,1, HALTD, 18, "halted_frozen");
        // async reset in the middle of a drain
        step(0, 0,0,0,0,0,0, RUNO, 0, "reset2");
        step(1, 0,0,0,0,0,0, RUNO, 0, "idle2");
        step(1, 0,0,0,0,0,1, HLT,  0, "halt2_req");
        step(1, 0,0,0,0,0,0, HLT,  1, "drain2");
        step(1, 0,0,0,0,0,0, HLT,  2, "drain2");
        step(0, 0,0,0,0,0,0, RUNO, 0, "reset_mid_drain");
        step(1, 0,0,0,0,0,0, RUNO, 0, "idle3");
        // plain memory wait, releases with no bubble
        step(1, 0,0,0,0,1,0, MEMH, 0, "dmem");
        step(1, 0,0,0,0,1,0, MEMH, 1, "dmem");
        step(1, 0,0,0,0,0,0, RUNO, 2, "dmem_release");
        step(1, 0,0,0,0,0,0, RUNO, 2, "dmem_idle");
        // MDU watchdog
        step(1, 0,0,1,0,0,0, MDU0, 2, "wd_start");
        for (int k = 0; k <= 64; k++)
            step(1, 0,0,0,0,0,0, (k == 0) ? MDU0 : MDUN, 3 + k, "wd_wait");
        step(1, 0,0,0,0,0,0, RUNTO, 68, "wd_timeout");
        step(1, 0,0,0,0,0,0, RUNTO, 68, "wd_sticky");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            checks++;
            $display("FAIL drain_queue: %0d left, expected 0", exp_q.size());
        end
        #2;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
